// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready holding registers.
// Optional macro DEMUX_1TO4_CNT_EN adds saturating per-channel drain counters (xfer_cnt).
module demux_1to4_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             auto_seq,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
`ifdef DEMUX_1TO4_CNT_EN
  output logic [31:0]      xfer_cnt,
`endif
  output logic [1:0]       cur_ch
);

  logic [1:0]       ptr;
  logic [WIDTH-1:0] data_p1 [4];
  logic             acc;
  logic [3:0]       load;
  logic [3:0]       drain;

  always_comb begin
    cur_ch   = auto_seq ? ptr : in_sel;
    // A full target that drains this cycle may be reloaded in the same cycle.
    in_ready = ~rst & (~out_valid[cur_ch] | out_ready[cur_ch]);
    acc      = in_valid & in_ready;
    load     = acc ? (4'b0001 << cur_ch) : 4'b0000;
    drain    = out_valid & out_ready;
  end

  // Stage p1: channel holding registers and rotating pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 2'b00;
      out_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) data_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) data_p1[i] <= in_data;
      end
      out_valid <= load | (out_valid & ~drain);
      if (acc && auto_seq) ptr <= ptr + 2'd1;
    end
  end

  assign out_a = data_p1[0];
  assign out_b = data_p1[1];
  assign out_c = data_p1[2];
  assign out_d = data_p1[3];

`ifdef DEMUX_1TO4_CNT_EN
  logic [7:0] cnt_p1 [4];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_p1[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drain[i]) cnt_p1[i] <= sat_inc(cnt_p1[i]);
      end
    end
  end

  assign xfer_cnt = {cnt_p1[3], cnt_p1[2], cnt_p1[1], cnt_p1[0]};
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Bench for demux_1to4_reg: directed vector table, async reset sequence, random run
// against a behavioural model, and drain counter saturation when DEMUX_1TO4_CNT_EN is set.
module tb_demux_1to4_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic       auto_seq;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] cur_ch;
`ifdef DEMUX_1TO4_CNT_EN
  logic [31:0] xfer_cnt;
`endif

  demux_1to4_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .auto_seq(auto_seq),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef DEMUX_1TO4_CNT_EN
    .xfer_cnt(xfer_cnt),
`endif
    .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vld;
    logic [3:0] a, b, c, d;
  } exp_t;

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic       au;
    logic [3:0] data;
    logic [3:0] ordy;
    logic       rdy;
    logic [1:0] cur;
    exp_t       e;
  } vec_t;

  exp_t q[$];
  vec_t tab[17];
  int   n_chk = 0;
  int   n_pass = 0;

  // Behavioural reference state
  logic [3:0] m_vld;
  logic [3:0] m_d [4];
  logic [1:0] m_ptr;
  int         m_cnt [4];
  logic       m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_vld = 4'b0000;
    m_ptr = 2'b00;
    for (int i = 0; i < 4; i++) begin
      m_d[i] = 4'h0;
      m_cnt[i] = 0;
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic au,
                              input logic [3:0] data, input logic [3:0] ordy, input logic rdy,
                              input logic [1:0] cur, input logic [3:0] vld, input logic [15:0] abcd);
    vec_t v;
    v.iv = iv; v.sel = sel; v.au = au; v.data = data; v.ordy = ordy;
    v.rdy = rdy; v.cur = cur; v.e = {vld, abcd};
    return v;
  endfunction

  // One clock: drive at negedge, check handshake, queue expected state, compare after posedge.
  task automatic run_cycle(input logic iv, input logic [1:0] sel, input logic au,
                           input logic [3:0] data, input logic [3:0] ordy,
                           input bit use_tab, input vec_t tv, input string name);
    logic [1:0] c;
    logic       r;
    exp_t       got, e;
    @(negedge clk);
    in_valid = iv; in_sel = sel; auto_seq = au; in_data = data; out_ready = ordy;
    #1;
    c = au ? m_ptr : sel;
    r = ~m_vld[c] | ordy[c];
    m_acc = iv & r;
    check({name, " in_ready"}, {31'd0, in_ready}, use_tab ? {31'd0, tv.rdy} : {31'd0, r});
    check({name, " cur_ch"}, {30'd0, cur_ch}, use_tab ? {30'd0, tv.cur} : {30'd0, c});
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i] && ordy[i] && m_cnt[i] < 255) m_cnt[i]++;
    end
    m_vld = m_vld & ~ordy;
    if (m_acc) begin
      m_d[c] = data;
      m_vld[c] = 1'b1;
      if (au) m_ptr = m_ptr + 2'd1;
    end
    q.push_back(use_tab ? tv.e : exp_t'({m_vld, m_d[0], m_d[1], m_d[2], m_d[3]}));
    @(posedge clk);
    #1;
    got = {out_valid, out_a, out_b, out_c, out_d};
    if (q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check({name, " out_valid"}, {28'd0, got.vld}, {28'd0, e.vld});
      check({name, " out_abcd"}, {16'd0, got.a, got.b, got.c, got.d}, {16'd0, e.a, e.b, e.c, e.d});
    end
`ifdef DEMUX_1TO4_CNT_EN
    if (!use_tab)
      check({name, " xfer_cnt"}, xfer_cnt,
            {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic       h_iv;
    logic [1:0] h_sel;
    logic [3:0] h_data;
    vec_t       nv;
    nv = mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);

    tab[0]  = mk(1, 2'd2, 0, 4'hA, 4'b0000, 1, 2'd2, 4'b0100, 16'h00A0);
    tab[1]  = mk(1, 2'd1, 0, 4'h3, 4'b0000, 1, 2'd1, 4'b0110, 16'h03A0);
    tab[2]  = mk(1, 2'd1, 0, 4'h7, 4'b0000, 0, 2'd1, 4'b0110, 16'h03A0);
    tab[3]  = mk(1, 2'd3, 0, 4'h5, 4'b0000, 1, 2'd3, 4'b1110, 16'h03A5);
    tab[4]  = mk(1, 2'd1, 0, 4'h7, 4'b0010, 1, 2'd1, 4'b1110, 16'h07A5);
    tab[5]  = mk(0, 2'd0, 0, 4'h0, 4'b1100, 1, 2'd0, 4'b0010, 16'h07A5);
    tab[6]  = mk(1, 2'd0, 1, 4'h1, 4'b1111, 1, 2'd0, 4'b0001, 16'h17A5);
    tab[7]  = mk(1, 2'd0, 1, 4'h2, 4'b1111, 1, 2'd1, 4'b0010, 16'h12A5);
    tab[8]  = mk(1, 2'd0, 1, 4'h3, 4'b1111, 1, 2'd2, 4'b0100, 16'h1235);
    tab[9]  = mk(1, 2'd0, 1, 4'h4, 4'b1111, 1, 2'd3, 4'b1000, 16'h1234);
    tab[10] = mk(1, 2'd0, 1, 4'h5, 4'b1111, 1, 2'd0, 4'b0001, 16'h5234);
    tab[11] = mk(1, 2'd1, 0, 4'h6, 4'b0000, 1, 2'd1, 4'b0011, 16'h5634);
    tab[12] = mk(1, 2'd0, 1, 4'h8, 4'b0000, 0, 2'd1, 4'b0011, 16'h5634);
    tab[13] = mk(0, 2'd0, 1, 4'h0, 4'b0000, 0, 2'd1, 4'b0011, 16'h5634);
    tab[14] = mk(1, 2'd0, 1, 4'h8, 4'b0010, 1, 2'd1, 4'b0011, 16'h5834);
    tab[15] = mk(0, 2'd0, 1, 4'h0, 4'b0000, 1, 2'd2, 4'b0011, 16'h5834);
    tab[16] = mk(1, 2'd0, 1, 4'h9, 4'b1111, 1, 2'd2, 4'b0100, 16'h5894);

    rst = 1'b1; in_data = 4'h0; in_sel = 2'd0; in_valid = 1'b1; auto_seq = 1'b0;
    out_ready = 4'b0000;
    model_reset();
    #12;
    check("reset out_valid", {28'd0, out_valid}, 32'd0);
    check("reset outs", {16'd0, out_a, out_b, out_c, out_d}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    foreach (tab[i]) run_cycle(tab[i].iv, tab[i].sel, tab[i].au, tab[i].data, tab[i].ordy,
                               1'b1, tab[i], $sformatf("vec%0d", i));

    // Fill every channel, then hit reset asynchronously mid-cycle.
    run_cycle(1, 2'd0, 0, 4'hE, 4'b0000, 1'b0, nv, "fill_a");
    run_cycle(1, 2'd1, 0, 4'hD, 4'b0000, 1'b0, nv, "fill_b");
    run_cycle(1, 2'd3, 0, 4'hC, 4'b0000, 1'b0, nv, "fill_d");
    check("full before reset", {28'd0, out_valid}, 32'hF);
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hF;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async reset out_valid", {28'd0, out_valid}, 32'd0);
    check("async reset outs", {16'd0, out_a, out_b, out_c, out_d}, 32'd0);
    check("async reset in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("no load during reset", {28'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; auto_seq = 1'b1;
    #1;
    check("ptr after reset", {30'd0, cur_ch}, 32'd0);
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    h_iv = 1'b0; h_sel = 2'd0; h_data = 4'h0;
    for (int n = 0; n < 200; n++) begin
      logic       au;
      logic [3:0] ordy;
      if (!(h_iv && !m_acc)) begin
        h_iv = ($urandom_range(0, 3) != 0);
        h_sel = 2'($urandom_range(0, 3));
        h_data = 4'($urandom_range(0, 15));
      end
      au = ($urandom_range(0, 1) == 1);
      ordy = 4'($urandom_range(0, 15));
      m_acc = 1'b0;
      run_cycle(h_iv, h_sel, au, h_data, ordy, 1'b0, nv, "rand");
    end

`ifdef DEMUX_1TO4_CNT_EN
    for (int n = 0; n < 302; n++)
      run_cycle(1, 2'd0, 0, 4'(n), 4'b0001, 1'b0, nv, "cnt_a");
    check("cnt byte0 saturated", {24'd0, xfer_cnt[7:0]}, 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_1to4_reg.md
Name: demux_1to4_reg

Overview:
- Registered 1-to-4 demultiplexer: the distribution end of the team's 4:1 channel mux datapath.
- One WIDTH-bit input stream with a 2-bit channel select is steered into one of four per-channel holding registers (a, b, c, d), each with its own valid/ready handshake.
- Select comes from the in_sel port (explicit mode) or from an internal rotating pointer (auto-sequence mode).
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 4, data width of input and of each output channel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input payload.
- in_sel  input  2  target channel (00=a, 01=b, 10=c, 11=d); used only when auto_seq=0.
- in_valid  input  1  producer has data.
- in_ready  output  1  block can accept in this cycle (combinational).
- auto_seq  input  1  1 = ignore in_sel and use the internal pointer.
- out_a, out_b, out_c, out_d  output  WIDTH each  per-channel registered data.
- out_valid  output  4  bit0=a .. bit3=d; channel register holds unconsumed data.
- out_ready  input  4  bit0=a .. bit3=d; consumer accepts.
- cur_ch  output  2  effective target channel this cycle.

Behaviour:
- Reset (async, rst=1): out_a..out_d=0, out_valid=0000, internal pointer=00. While rst=1, in_ready=0 and no transfer occurs. Reset mid-transfer discards all held data. Release is synchronous to the next clk edge.
- Effective channel: cur_ch = auto_seq ? ptr : in_sel (combinational).
- Accept condition: acc = in_valid & in_ready.
- in_ready = ~out_valid[cur_ch] | out_ready[cur_ch]. A full channel draining in the same cycle can be reloaded, giving full throughput. Full channels not selected never block.
- On acc at a rising edge:
  - out_<cur_ch> <= in_data.
  - out_valid[cur_ch] <= 1.
- Drain: at each edge, for each channel i with out_valid[i]&out_ready[i] and no simultaneous load of i, out_valid[i] <= 0. Simultaneous load and drain of the same channel keeps valid=1 with the new data.
- Data registers hold their last value after drain; they update only on load.
- Latency: 1 cycle from accepted input to out_valid on the target channel.
- Loads and drains on different channels in the same cycle are independent.
- Pointer:
  - Increments mod 4 (11 -> 00 wraps) only on acc while auto_seq=1.
  - Holds otherwise. Stalls (in_ready=0) do not advance it.
- auto_seq may change on any cycle. It takes effect on cur_ch the same cycle. The pointer keeps its value across mode switches.
- No data loss: a held value is never overwritten unless it drains in the same cycle.
- in_valid=1 while in_ready=0 is a stall, not an error. The producer must hold in_data and in_sel stable until accepted.

Optional Feature:
- Macro: DEMUX_1TO4_CNT_EN.
- Defined:
  - Adds output port xfer_cnt (4x8 = 32 bits; byte i = channel i).
  - Each byte counts completed drains (out_valid[i]&out_ready[i]) on channel i.
  - Saturates at 255. Reset to 0 by rst.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-run with all four channels full -> out_valid=0000, out_a..d=0, in_ready=0 during reset, ptr=00 after release.
- Explicit steer: auto_seq=0, send in_sel=10 data=4'hA with out_ready=0000 -> next cycle out_c=A, out_valid=0100, other outputs unchanged.
- Backpressure: channel b full, out_ready[1]=0, in_sel=01, in_valid=1 -> in_ready=0, out_b keeps old value. Raise out_ready[1] -> same-cycle reload: out_b=new value, out_valid[1] stays 1.
- Non-blocking: channel b full and stalled, send in_sel=11 data=4'h5 -> accepted, out_d=5, b unaffected.
- Auto sequence: auto_seq=1, out_ready=1111, stream 1,2,3,4,5 back-to-back -> out_a=1, b=2, c=3, d=4, a=5. ptr wraps to 01. Insert one stall cycle -> ptr does not advance.
- Counter (DEMUX_1TO4_CNT_EN): 300 drains on channel a -> xfer_cnt byte0=255, other bytes match their own drain counts.
